// File: rtl/depth_sort_engine.sv
`default_nettype none
// ============================================================================
// Module      : depth_sort_engine
// Description : Loads up to MAX_TRIS depth keys, sorts them stably with an
//               odd-even transposition network, and streams index/key pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module depth_sort_engine #(
    parameter int MAX_TRIS = 24,
    parameter int IDX_W    = 5,
    parameter int DEPTH_W  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IDX_W:0]     num_tris,
    input  logic               descending,
    input  logic               in_valid,
    input  logic [DEPTH_W-1:0] in_key,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic [DEPTH_W-1:0] out_key,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_SORT  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    localparam logic [IDX_W:0] c_MAX_N = (IDX_W+1)'(MAX_TRIS);
    localparam logic [IDX_W:0] c_ONE   = (IDX_W+1)'(1);

    logic [1:0]         r_state;
    logic [IDX_W:0]     r_n;
    logic               r_desc;
    logic [IDX_W:0]     r_cnt;
    logic               r_zero_done;
    logic [DEPTH_W-1:0] r_key [MAX_TRIS];
    logic [IDX_W-1:0]   r_idx [MAX_TRIS];

    logic [1:0]         w_state_nxt;
    logic [IDX_W:0]     w_n_nxt;
    logic               w_desc_nxt;
    logic [IDX_W:0]     w_cnt_nxt;
    logic               w_zero_done_nxt;
    logic [IDX_W:0]     w_n_clamp;
    logic [IDX_W-1:0]   w_slot;
    logic               w_last;
    logic [MAX_TRIS-2:0] w_swap;
    logic [DEPTH_W-1:0] w_key_nxt [MAX_TRIS];
    logic [IDX_W-1:0]   w_idx_nxt [MAX_TRIS];

    assign w_n_clamp = (num_tris > c_MAX_N) ? c_MAX_N : num_tris;
    assign w_slot    = r_cnt[IDX_W-1:0];
    assign w_last    = (r_cnt == (r_n - c_ONE));

    // Phase parity follows the counter LSB; pairs reaching past N stay idle.
    for (genvar g = 0; g < MAX_TRIS-1; g++) begin : g_pair
        localparam logic           c_ODD = (g % 2) == 1;
        localparam logic [IDX_W:0] c_HI  = (IDX_W+1)'(g + 1);
        assign w_swap[g] = (r_cnt[0] == c_ODD) && (c_HI < r_n) &&
                           (r_desc ? (r_key[g] < r_key[g+1])
                                   : (r_key[g] > r_key[g+1]));
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_n_nxt         = r_n;
        w_desc_nxt      = r_desc;
        w_cnt_nxt       = r_cnt;
        w_zero_done_nxt = 1'b0;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        out_last        = 1'b0;
        out_index       = '0;
        out_key         = '0;
        busy            = (r_state != c_ST_IDLE);
        done            = r_zero_done;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_n_nxt    = w_n_clamp;
                    w_desc_nxt = descending;
                    w_cnt_nxt  = '0;
                    if (w_n_clamp == '0) begin
                        w_zero_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_LOAD;
                    end
                end
            end
            c_ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_last) begin
                        w_state_nxt = c_ST_SORT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end
            end
            c_ST_SORT: begin
                if (w_last) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            c_ST_DRAIN: begin
                out_valid = 1'b1;
                out_index = r_idx[w_slot];
                out_key   = r_key[w_slot];
                out_last  = w_last;
                if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = '0;
                        done        = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_n         <= '0;
            r_desc      <= 1'b0;
            r_cnt       <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_n         <= w_n_nxt;
            r_desc      <= w_desc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_zero_done <= w_zero_done_nxt;
        end
    end

    // Pairs within one phase are disjoint, so all swaps read the old slots.
    always_comb begin
        w_key_nxt = r_key;
        w_idx_nxt = r_idx;
        if ((r_state == c_ST_LOAD) && in_valid) begin
            w_key_nxt[w_slot] = in_key;
            w_idx_nxt[w_slot] = w_slot;
        end else if (r_state == c_ST_SORT) begin
            for (int i = 0; i < MAX_TRIS-1; i++) begin
                if (w_swap[i]) begin
                    w_key_nxt[i]   = r_key[i+1];
                    w_key_nxt[i+1] = r_key[i];
                    w_idx_nxt[i]   = r_idx[i+1];
                    w_idx_nxt[i+1] = r_idx[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        r_key <= w_key_nxt;
        r_idx <= w_idx_nxt;
    end

endmodule
`default_nettype wire

// File: tb/tb_depth_sort_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_depth_sort_engine
// Description : Directed bench for depth_sort_engine with a stable-sort model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_depth_sort_engine;

    localparam int MAX_TRIS = 24;
    localparam int IDX_W    = 5;
    localparam int DEPTH_W  = 12;

    logic               clk        = 1'b0;
    logic               rst_n      = 1'b0;
    logic               start      = 1'b0;
    logic [IDX_W:0]     num_tris   = '0;
    logic               descending = 1'b0;
    logic               in_valid   = 1'b0;
    logic [DEPTH_W-1:0] in_key     = '0;
    logic               out_ready  = 1'b1;
    logic               in_ready;
    logic               out_valid;
    logic [IDX_W-1:0]   out_index;
    logic [DEPTH_W-1:0] out_key;
    logic               out_last;
    logic               busy;
    logic               done;

    depth_sort_engine #(
        .MAX_TRIS (MAX_TRIS),
        .IDX_W    (IDX_W),
        .DEPTH_W  (DEPTH_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_tris   (num_tris),
        .descending (descending),
        .in_valid   (in_valid),
        .in_key     (in_key),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_key    (out_key),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int key;
        bit last;
    } beat_t;

    beat_t              exp_q[$];
    int                 keys[32];
    int                 got_idx[32];
    int                 got_key[32];
    int                 beats;
    int                 total;
    int                 bad;
    bit                 rdy_rand;
    bit                 zero_done_exp;
    bit                 stalled;
    logic [IDX_W-1:0]   st_idx;
    logic [DEPTH_W-1:0] st_key;
    logic               st_last;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Expected order: repeatedly take the best remaining key, lowest index on ties.
    task automatic build_model(input int n, input bit desc);
        bit taken[32];
        exp_q.delete();
        for (int j = 0; j < 32; j++) taken[j] = 1'b0;
        for (int r = 0; r < n; r++) begin
            int best;
            best = -1;
            for (int j = 0; j < n; j++) begin
                if (!taken[j]) begin
                    if (best < 0 || (desc ? (keys[j] > keys[best]) : (keys[j] < keys[best])))
                        best = j;
                end
            end
            taken[best] = 1'b1;
            exp_q.push_back('{best, keys[best], (r == n-1)});
        end
    endtask

    always @(negedge clk) begin
        bit exp_done;
        exp_done = zero_done_exp;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                chk("out_index", out_index, exp_q[0].idx);
                chk("out_key", out_key, exp_q[0].key);
                chk("out_last", out_last, exp_q[0].last);
                if (stalled) begin
                    chk("stall_index", out_index, st_idx);
                    chk("stall_key", out_key, st_key);
                    chk("stall_last", out_last, st_last);
                end
                if (out_ready) begin
                    exp_done = exp_q[0].last;
                    if (beats < 32) begin
                        got_idx[beats] = out_index;
                        got_key[beats] = out_key;
                    end
                    beats++;
                    void'(exp_q.pop_front());
                end
            end
            stalled = !out_ready;
            st_idx  = out_index;
            st_key  = out_key;
            st_last = out_last;
        end else begin
            stalled = 1'b0;
        end
        chk("done", done, exp_done);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_job(input int n_req, input bit desc);
        int n;
        n = (n_req > MAX_TRIS) ? MAX_TRIS : n_req;
        build_model(n, desc);
        beats      = 0;
        start      = 1'b1;
        num_tris   = (IDX_W+1)'(n_req);
        descending = desc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic load_keys(input int n);
        for (int j = 0; j < n; j++) begin
            int waited;
            waited   = 0;
            in_valid = 1'b1;
            in_key   = DEPTH_W'(keys[j]);
            @(negedge clk);
            while (!in_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                chk("load_timeout", j, n);
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic count_sort(input int n, input bit poke);
        int c;
        c = 0;
        @(negedge clk);
        chk("busy_sort", busy, 1);
        while (!out_valid && c < 200) begin
            if (poke && c == 1) begin
                start    = 1'b1;
                num_tris = (IDX_W+1)'(3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk("sort_cycles", c, n);
    endtask

    task automatic wait_done(input int n, input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!done) chk("done_timeout", c, budget);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("beat_count", beats, n);
        chk("queue_left", exp_q.size(), 0);
    endtask

    task automatic run_job(input int n_req, input bit desc, input bit poke);
        int n;
        n = (n_req > MAX_TRIS) ? MAX_TRIS : n_req;
        start_job(n_req, desc);
        load_keys(n);
        count_sort(n, poke);
        wait_done(n, n * 40 + 50);
    endtask

    initial begin
        int c;
        total = 0;
        bad = 0;
        beats = 0;
        rdy_rand = 1'b0;
        zero_done_exp = 1'b0;
        stalled = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_key", out_key, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-front with a tie on 40
        keys[0] = 10; keys[1] = 40; keys[2] = 20; keys[3] = 40;
        run_job(4, 1'b1, 1'b0);
        chk("t1_idx0", got_idx[0], 1);
        chk("t1_idx1", got_idx[1], 3);
        chk("t1_idx2", got_idx[2], 2);
        chk("t1_idx3", got_idx[3], 0);
        chk("t1_key0", got_key[0], 40);
        chk("t1_key3", got_key[3], 10);

        // Front-to-back, with a start pulse landing mid-sort
        run_job(4, 1'b0, 1'b1);
        chk("t2_idx0", got_idx[0], 0);
        chk("t2_idx1", got_idx[1], 2);
        chk("t2_idx2", got_idx[2], 1);
        chk("t2_idx3", got_idx[3], 3);

        // Empty job
        @(posedge clk);
        #1;
        start    = 1'b1;
        num_tris = '0;
        @(posedge clk);
        #1;
        start         = 1'b0;
        zero_done_exp = 1'b1;
        @(negedge clk);
        chk("zero_in_ready", in_ready, 0);
        chk("zero_busy", busy, 0);
        @(posedge clk);
        #1;
        zero_done_exp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("zero_in_ready_later", in_ready, 0);
        end

        // Oversized request clamps to MAX_TRIS
        for (int j = 0; j < 32; j++) keys[j] = (j * 37) % 101;
        run_job(31, 1'b1, 1'b0);

        // Reverse-ordered keys with a stalling consumer
        for (int j = 0; j < MAX_TRIS; j++) keys[j] = 4095 - j * 178;
        rdy_rand = 1'b1;
        run_job(24, 1'b0, 1'b0);
        rdy_rand = 1'b0;
        chk("t5_first", got_idx[0], 23);
        chk("t5_last", got_idx[23], 0);
        chk("t5_min_key", got_key[0], 1);

        // Single triangle
        keys[0] = 7;
        run_job(1, 1'b1, 1'b0);
        chk("t6_idx", got_idx[0], 0);

        // All keys equal keep original order
        for (int j = 0; j < 5; j++) keys[j] = 100;
        run_job(5, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) chk("t7_tie_order", got_idx[j], j);

        // Full-range unsigned keys
        keys[0] = 0; keys[1] = 4095; keys[2] = 2048;
        run_job(3, 1'b1, 1'b0);
        chk("t8_idx0", got_idx[0], 1);
        chk("t8_idx1", got_idx[1], 2);
        chk("t8_idx2", got_idx[2], 0);

        // Reset in the middle of draining
        keys[0] = 5; keys[1] = 6; keys[2] = 7; keys[3] = 8;
        start_job(4, 1'b1);
        load_keys(4);
        count_sort(4, 1'b0);
        c = 0;
        while (beats < 2 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("abort_reached", (beats >= 2) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        stalled = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_last", out_last, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_quiet", out_valid, 0);
        end

        keys[0] = 9; keys[1] = 3;
        run_job(2, 1'b0, 1'b0);
        chk("t9_idx0", got_idx[0], 1);
        chk("t9_idx1", got_idx[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
